// File: rtl/key_search_scheduler.sv
// key_search_scheduler: hands ascending RC4 candidate keys to NUM_CORES crack cores,
// counts results and aborts every core on the first key that decodes cleanly.
package key_search_scheduler_pkg;
  typedef struct packed {
    logic launch;
    logic kill;
    logic abort;
  } slot_req_t;
endpackage

module key_search_slot
  import key_search_scheduler_pkg::*;
#(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  slot_req_t        req,
  input  logic [KEY_W-1:0] key_in,
  input  logic             done,
  output logic             busy,
  output logic             start,
  output logic             abort,
  output logic [KEY_W-1:0] key
);
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic [KEY_W-1:0] key_q, key_d;

  // launch wins over kill so a restart can clear every slot and refill slot 0 on one edge
  always_comb begin
    busy_d = busy_q & ~done;
    if (req.kill)   busy_d = 1'b0;
    if (req.launch) busy_d = 1'b1;
    key_d   = req.launch ? key_in : key_q;
    start_d = req.launch;
    abort_d = req.abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      key_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      start_q <= start_d;
      abort_q <= abort_d;
      key_q   <= key_d;
    end
  end

  assign busy  = busy_q;
  assign start = start_q;
  assign abort = abort_q;
  assign key   = key_q;
endmodule

module key_search_scheduler
  import key_search_scheduler_pkg::*;
#(
  parameter int               NUM_CORES = 4,
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_LO    = '0,
  parameter logic [KEY_W-1:0] KEY_HI    = KEY_W'(24'h3FFFFF)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic [NUM_CORES-1:0]     core_abort,
  input  logic [NUM_CORES-1:0]     core_done,
  input  logic [NUM_CORES-1:0]     core_found,
  output logic                     busy,
  output logic                     found,
  output logic                     exhausted,
  output logic [KEY_W-1:0]         found_key,
  output logic [KEY_W:0]           keys_done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_FAIL} state_e;

  // one spare bit on next_key lets KEY_HI = all-ones finish without wrapping
  localparam logic [KEY_W:0] LO_X  = {1'b0, KEY_LO};
  localparam logic [KEY_W:0] HI_X  = {1'b0, KEY_HI};
  localparam logic [KEY_W:0] ONE_X = (KEY_W+1)'(1);

  state_e           state_q, state_d;
  logic [KEY_W:0]   next_key_q, next_key_d;
  logic [KEY_W:0]   keys_done_q, keys_done_d;
  logic [KEY_W-1:0] found_key_q, found_key_d;

  logic [NUM_CORES-1:0]            busy_v, done_v, found_v, launch_v, abort_v;
  logic [NUM_CORES-1:0]            start_v, abort_q_v, pick;
  logic [NUM_CORES-1:0][KEY_W-1:0] key_v;
  slot_req_t [NUM_CORES-1:0]       req_v;
  logic                            restart, hit, keys_left, dispatch;
  logic [KEY_W-1:0]                win_key, launch_key;
  logic [KEY_W:0]                  done_cnt;

  always_comb begin
    done_v    = core_done & busy_v;
    found_v   = done_v & core_found;
    hit       = (state_q == S_RUN) && (|found_v);
    restart   = start && (state_q != S_RUN);
    keys_left = next_key_q <= HI_X;
    pick      = '0;
    win_key   = '0;
    done_cnt  = '0;
    // descending scan so the lowest index is the one left standing
    for (int c = NUM_CORES-1; c >= 0; c--) begin
      if (!busy_v[c]) begin
        pick    = '0;
        pick[c] = 1'b1;
      end
      if (found_v[c]) win_key = key_v[c];
      done_cnt = done_cnt + (KEY_W+1)'(done_v[c]);
    end
    dispatch   = (state_q == S_RUN) && !hit && keys_left && (|pick);
    launch_v   = '0;
    launch_key = next_key_q[KEY_W-1:0];
    if (restart) begin
      launch_v[0] = 1'b1;
      launch_key  = KEY_LO;
    end else if (dispatch) begin
      launch_v = pick;
    end
    abort_v = hit ? (busy_v & ~core_done) : '0;

    state_d     = state_q;
    next_key_d  = next_key_q;
    keys_done_d = keys_done_q;
    found_key_d = found_key_q;
    case (state_q)
      S_RUN: begin
        keys_done_d = keys_done_q + done_cnt;
        if (hit) begin
          state_d     = S_FOUND;
          found_key_d = win_key;
        end else begin
          if (dispatch) next_key_d = next_key_q + ONE_X;
          if (!keys_left && (busy_v == '0)) state_d = S_FAIL;
        end
      end
      default: begin
        if (restart) begin
          state_d     = S_RUN;
          next_key_d  = LO_X + ONE_X;
          keys_done_d = '0;
          found_key_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      next_key_q  <= LO_X;
      keys_done_q <= '0;
      found_key_q <= '0;
    end else begin
      state_q     <= state_d;
      next_key_q  <= next_key_d;
      keys_done_q <= keys_done_d;
      found_key_q <= found_key_d;
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_slot
    assign req_v[c] = {launch_v[c], hit | restart, abort_v[c]};
    key_search_slot #(.KEY_W(KEY_W)) u_slot (
      .clk    (CLOCK_50),
      .rst    (reset),
      .req    (req_v[c]),
      .key_in (launch_key),
      .done   (core_done[c]),
      .busy   (busy_v[c]),
      .start  (start_v[c]),
      .abort  (abort_q_v[c]),
      .key    (key_v[c])
    );
  end

  assign core_start = start_v;
  assign core_abort = abort_q_v;
  assign core_key   = key_v;
  assign busy       = state_q == S_RUN;
  assign found      = state_q == S_FOUND;
  assign exhausted  = state_q == S_FAIL;
  assign found_key  = found_key_q;
  assign keys_done  = keys_done_q;
endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: bench-side core models with random latency drive two
// configurations; a scoreboard predicts dispatch order, aborts, counts and final status.
module tb_key_search_scheduler;
  localparam int NA = 4;
  localparam int NB = 2;
  localparam int KW = 24;
  localparam int A_LO = 0;
  localparam int A_HI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               a_rst, a_start, a_busy, a_fnd, a_exh;
  logic [NA-1:0]      a_done, a_found, a_cstart, a_abort;
  logic [NA*KW-1:0]   a_key;
  logic [KW-1:0]      a_fkey;
  logic [KW:0]        a_kd;

  logic               b_rst, b_start, b_busy, b_fnd, b_exh;
  logic [NB-1:0]      b_done, b_found, b_cstart, b_abort;
  logic [NB*KW-1:0]   b_key;
  logic [KW-1:0]      b_fkey;
  logic [KW:0]        b_kd;

  int total = 0;
  int bad   = 0;

  key_search_scheduler #(.NUM_CORES(NA), .KEY_W(KW), .KEY_LO(24'h000000), .KEY_HI(24'h000005)) dut_a (
    .CLOCK_50(clk), .reset(a_rst), .start(a_start), .core_start(a_cstart), .core_key(a_key),
    .core_abort(a_abort), .core_done(a_done), .core_found(a_found), .busy(a_busy), .found(a_fnd),
    .exhausted(a_exh), .found_key(a_fkey), .keys_done(a_kd));

  key_search_scheduler #(.NUM_CORES(NB), .KEY_W(KW), .KEY_LO(24'hFFFFFF), .KEY_HI(24'hFFFFFF)) dut_b (
    .CLOCK_50(clk), .reset(b_rst), .start(b_start), .core_start(b_cstart), .core_key(b_key),
    .core_abort(b_abort), .core_done(b_done), .core_found(b_found), .busy(b_busy), .found(b_fnd),
    .exhausted(b_exh), .found_key(b_fkey), .keys_done(b_kd));

  // Full search on dut_a. Cores finish after fixlat cycles (0 = random 1..8); the core
  // holding key 'target' reports found. noise adds spurious done/found on idle cores and
  // start pulses while running, none of which may have any effect.
  task automatic run_search(input int target, input int fixlat, input bit noise);
    int cyc, win, exp_sc, exp_next, ndone, exp_fkey;
    int rem[NA];
    logic [KW-1:0] jk[NA];
    logic [NA-1:0] exp_ab, rdone, exp_sv;
    logic [KW-1:0] k;
    bit fpend, exh_pred, fin, all_idle;
    for (int c = 0; c < NA; c++) begin rem[c] = 0; jk[c] = '0; end
    exp_next = A_LO; ndone = 0; fpend = 0; exh_pred = 0; fin = 0; exp_fkey = 0;
    exp_ab = '0; cyc = 0;
    @(negedge clk); a_start = 1'b1; a_done = '0; a_found = '0; exp_sc = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk); cyc++;
      a_start = 1'b0; a_done = '0; a_found = '0;
      exp_sv = '0;
      if (exp_sc >= 0) exp_sv[exp_sc] = 1'b1;
      total++;
      if (a_cstart !== exp_sv) begin bad++; $display("FAIL core_start cyc=%0d got=%b want=%b", cyc, a_cstart, exp_sv); end
      for (int c = 0; c < NA; c++) if (a_cstart[c]) begin
        k = a_key[c*KW +: KW];
        total++;
        if (k !== KW'(exp_next)) begin bad++; $display("FAIL core_key core=%0d got=%h want=%h", c, k, KW'(exp_next)); end
        jk[c] = k;
        rem[c] = (fixlat > 0) ? fixlat : int'($urandom_range(1, 8));
        exp_next++;
      end
      if (fpend) begin
        total++;
        if (a_fnd !== 1'b1) begin bad++; $display("FAIL found got=%b want=1", a_fnd); end
        total++;
        if (a_fkey !== KW'(exp_fkey)) begin bad++; $display("FAIL found_key got=%h want=%h", a_fkey, KW'(exp_fkey)); end
        total++;
        if (a_fkey !== KW'(target)) begin bad++; $display("FAIL found_key_target got=%h want=%h", a_fkey, KW'(target)); end
        total++;
        if (a_abort !== exp_ab) begin bad++; $display("FAIL core_abort got=%b want=%b", a_abort, exp_ab); end
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL busy_after_found got=%b want=0", a_busy); end
        fin = 1;
      end else begin
        total++;
        if (a_exh !== exh_pred) begin bad++; $display("FAIL exhausted cyc=%0d got=%b want=%b", cyc, a_exh, exh_pred); end
        total++;
        if (a_abort !== '0) begin bad++; $display("FAIL stray_abort got=%b want=0", a_abort); end
        if (exh_pred) begin
          total++;
          if ({a_busy, a_fnd} !== 2'b00) begin bad++; $display("FAIL fail_status busy/found got=%b want=00", {a_busy, a_fnd}); end
          fin = 1;
        end else begin
          total++;
          if (a_busy !== 1'b1) begin bad++; $display("FAIL busy cyc=%0d got=%b want=1", cyc, a_busy); end
          rdone = '0; win = -1;
          for (int c = 0; c < NA; c++) if (rem[c] > 0 && !a_cstart[c]) begin
            rem[c]--;
            if (rem[c] == 0) begin
              rdone[c] = 1'b1; a_done[c] = 1'b1; ndone++;
              if (int'(jk[c]) == target) begin
                a_found[c] = 1'b1;
                if (win < 0) win = c;
              end
            end
          end
          if (noise && a_busy) begin
            for (int c = 0; c < NA; c++)
              if (rem[c] == 0 && !rdone[c] && $urandom_range(0, 3) == 0) begin a_done[c] = 1'b1; a_found[c] = 1'b1; end
            if ($urandom_range(0, 2) == 0) a_start = 1'b1;
          end
          exp_sc = -1; exh_pred = 0;
          all_idle = 1;
          for (int c = 0; c < NA; c++) if (rem[c] > 0) all_idle = 0;
          if (win >= 0) begin
            fpend = 1; exp_fkey = int'(jk[win]); exp_ab = '0;
            for (int c = 0; c < NA; c++) if (rem[c] > 0) exp_ab[c] = 1'b1;
          end else if (exp_next <= A_HI) begin
            for (int c = NA-1; c >= 0; c--) if (rem[c] == 0 && !rdone[c]) exp_sc = c;
          end else begin
            exh_pred = all_idle && (rdone == '0);
          end
        end
      end
    end
    a_start = 1'b0; a_done = '0; a_found = '0;
    total++;
    if (!fin) begin bad++; $display("FAIL search_timeout cycles=%0d limit=400", cyc); end
    total++;
    if (a_kd !== (KW+1)'(ndone)) begin bad++; $display("FAIL keys_done got=%0d want=%0d", a_kd, ndone); end
    total++;
    if (a_fnd !== 1'(target >= A_LO && target <= A_HI)) begin bad++; $display("FAIL outcome found=%b target=%0d", a_fnd, target); end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({a_busy, a_fnd, a_exh, a_cstart, a_abort} !== '0 || a_key !== '0 || a_fkey !== '0 || a_kd !== '0) begin
      bad++; $display("FAIL reset_a busy=%b found=%b exh=%b start=%b abort=%b kd=%0d want all 0", a_busy, a_fnd, a_exh, a_cstart, a_abort, a_kd);
    end
    total++;
    if ({b_busy, b_fnd, b_exh, b_cstart, b_abort} !== '0 || b_key !== '0 || b_fkey !== '0 || b_kd !== '0) begin
      bad++; $display("FAIL reset_b busy=%b found=%b exh=%b start=%b abort=%b kd=%0d want all 0", b_busy, b_fnd, b_exh, b_cstart, b_abort, b_kd);
    end
    @(negedge clk); a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_busy, a_cstart, b_busy, b_cstart} !== '0) begin bad++; $display("FAIL idle_after_reset got=%b want=0", {a_busy, a_cstart, b_busy, b_cstart}); end
  endtask

  task automatic test_exhaust();
    run_search(-1, 10, 1'b0);
    total++;
    if (a_kd !== 25'd6) begin bad++; $display("FAIL exhaust_keys_done got=%0d want=6", a_kd); end
    total++;
    if ({a_exh, a_fnd, a_busy} !== 3'b100) begin bad++; $display("FAIL exhaust_status exh/found/busy got=%b want=100", {a_exh, a_fnd, a_busy}); end
  endtask

  task automatic test_found();
    int target;
    for (int it = 0; it < 6; it++) begin
      target = int'($urandom_range(A_LO, A_HI));
      run_search(target, 0, it[0]);
      for (int h = 0; h < 4; h++) begin
        @(negedge clk);
        total++;
        if ({a_fnd, a_busy, a_cstart, a_abort} !== {2'b10, {2*NA{1'b0}}} || a_fkey !== KW'(target)) begin
          bad++; $display("FAIL found_hold found=%b busy=%b start=%b abort=%b key=%h want key=%h", a_fnd, a_busy, a_cstart, a_abort, a_fkey, KW'(target));
        end
      end
    end
  endtask

  task automatic test_multi_found();
    logic [NA-1:0] sv;
    @(negedge clk); a_start = 1'b1;
    for (int k = 0; k < NA; k++) begin
      @(negedge clk); a_start = 1'b0; sv = '0; sv[k] = 1'b1;
      total++;
      if (a_cstart !== sv) begin bad++; $display("FAIL multi_dispatch got=%b want=%b", a_cstart, sv); end
    end
    @(negedge clk); a_done = 4'b1010; a_found = 4'b1010;
    @(negedge clk); a_done = '0; a_found = '0;
    total++;
    if (a_fnd !== 1'b1 || a_fkey !== KW'(A_LO + 1)) begin bad++; $display("FAIL multi_found found=%b key=%h want 1/%h", a_fnd, a_fkey, KW'(A_LO + 1)); end
    total++;
    if (a_abort !== 4'b0101) begin bad++; $display("FAIL multi_abort got=%b want=0101", a_abort); end
    total++;
    if (a_kd !== 25'd2) begin bad++; $display("FAIL multi_keys_done got=%0d want=2", a_kd); end
    @(negedge clk);
    total++;
    if (a_abort !== '0) begin bad++; $display("FAIL multi_abort_pulse got=%b want=0000", a_abort); end
  endtask

  task automatic test_single_key();
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    total++;
    if (b_cstart !== 2'b01 || b_key[KW-1:0] !== 24'hFFFFFF) begin bad++; $display("FAIL single_dispatch start=%b key=%h want 01/ffffff", b_cstart, b_key[KW-1:0]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (b_cstart !== 2'b00 || b_busy !== 1'b1) begin bad++; $display("FAIL single_no_wrap start=%b busy=%b want 00/1", b_cstart, b_busy); end
    end
    b_done = 2'b01;
    @(negedge clk); b_done = 2'b00;
    total++;
    if (b_exh !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL single_early_exh exh=%b busy=%b want 0/1", b_exh, b_busy); end
    @(negedge clk);
    total++;
    if ({b_exh, b_fnd, b_busy} !== 3'b100 || b_kd !== 25'd1) begin bad++; $display("FAIL single_exh status=%b kd=%0d want 100/1", {b_exh, b_fnd, b_busy}, b_kd); end
    total++;
    if (b_key[2*KW-1:KW] !== '0 || b_cstart !== 2'b00) begin bad++; $display("FAIL single_core1 key=%h start=%b want 0/00", b_key[2*KW-1:KW], b_cstart); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    @(negedge clk); a_done = 4'b0001;
    @(negedge clk); a_done = '0;
    total++;
    if (a_kd !== 25'd1) begin bad++; $display("FAIL mid_keys_done got=%0d want=1", a_kd); end
    #2 a_rst = 1'b1;
    #1;
    total++;
    if ({a_busy, a_fnd, a_exh, a_cstart, a_abort} !== '0 || a_key !== '0 || a_fkey !== '0 || a_kd !== '0) begin
      bad++; $display("FAIL mid_reset busy=%b start=%b abort=%b kd=%0d want all 0", a_busy, a_cstart, a_abort, a_kd);
    end
    @(negedge clk); a_rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_busy, a_cstart, a_abort} !== '0) begin bad++; $display("FAIL mid_idle busy=%b start=%b abort=%b want 0", a_busy, a_cstart, a_abort); end
    run_search(-1, 0, 1'b0);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_done = '0; a_found = '0; b_done = '0; b_found = '0;
    test_reset();
    test_exhaust();
    run_search(-1, 0, 1'b1);
    test_found();
    test_multi_found();
    test_single_key();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
